// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus the decode-side
// valid/ready port.
interface instr_fetch_unit_if #(
   parameter int PC_W = 16
);
   logic            imem_req_o;
   logic [PC_W-1:0] imem_addr_o;
   logic            imem_ack_i;
   logic [15:0]     imem_rdata_i;
   logic            instr_valid_o;
   logic [15:0]     instr_o;
   logic [3:0]      opcode_o;
   logic [PC_W-1:0] pc_o;
   logic            id_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
      input  imem_ack_i, imem_rdata_i, id_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
      output imem_ack_i, imem_rdata_i, id_ready_i
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit instructions over req/ack, hands
// them to decode and redirects on taken branches/jumps from execute.
module instr_fetch_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  bus,
   input  logic                ex_beq_i,
   input  logic                ex_bne_i,
   input  logic                ex_jump_i,
   input  logic                ex_zero_i,
   input  logic [PC_W-1:0]     ex_pc_i,
   input  logic [11:0]         ex_imm_i,
   output logic                redirect_o,
   output logic [15:0]         fetch_count_o
);

   typedef enum logic [1:0] {
      START,
      FETCH,
      VALID,
      DISCARD
   } state_e;

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [PC_W-1:0] addr_q, addr_d;
   logic [PC_W-1:0] next_pc_q, next_pc_d;
   logic            valid_q, valid_d;
   logic [15:0]     instr_q, instr_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            redirect_q, redirect_d;
   logic [15:0]     count_q, count_d;

   logic            take;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] target;

   assign take     = ex_jump_i | (ex_beq_i & ex_zero_i) | (ex_bne_i & ~ex_zero_i);
   assign pc_plus1 = ex_pc_i + PC_W'(1);

   // Jump keeps the upper PC bits of pc+1; branches use a 4-bit signed offset.
   assign target = ex_jump_i ? {pc_plus1[PC_W-1:12], ex_imm_i}
                             : pc_plus1 + {{(PC_W-4){ex_imm_i[3]}}, ex_imm_i[3:0]};

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      req_d      = req_q;
      addr_d     = addr_q;
      next_pc_d  = next_pc_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      count_d    = count_q;
      redirect_d = take;

      unique case (state_q)
         START: begin
            req_d   = 1'b1;
            addr_d  = next_pc_q;
            state_d = FETCH;
         end
         FETCH: begin
            if (bus.imem_ack_i) begin
               if (take) begin
                  req_d     = 1'b1;
                  addr_d    = target;
                  next_pc_d = target + PC_W'(1);
               end else begin
                  instr_d   = bus.imem_rdata_i;
                  pc_d      = addr_q;
                  valid_d   = 1'b1;
                  next_pc_d = addr_q + PC_W'(1);
                  req_d     = 1'b0;
                  state_d   = VALID;
               end
            end else if (take) begin
               // The outstanding request cannot be withdrawn; remember where to go.
               next_pc_d = target;
               state_d   = DISCARD;
            end
         end
         VALID: begin
            if (take) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = target;
               state_d = FETCH;
            end else if (bus.id_ready_i) begin
               count_d = count_q + 16'd1;
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = next_pc_q;
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (take) begin
               next_pc_d = target;
            end
            if (bus.imem_ack_i) begin
               req_d   = 1'b1;
               addr_d  = take ? target : next_pc_q;
               state_d = FETCH;
            end
         end
         default: state_d = START;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= START;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         next_pc_q  <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         redirect_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         next_pc_q  <= next_pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         count_q    <= count_d;
      end
   end

   assign bus.imem_req_o    = req_q;
   assign bus.imem_addr_o   = addr_q;
   assign bus.instr_valid_o = valid_q;
   assign bus.instr_o       = instr_q;
   assign bus.opcode_o      = instr_q[15:12];
   assign bus.pc_o          = pc_q;
   assign redirect_o        = redirect_q;
   assign fetch_count_o     = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero/multi-wait fetch, decode
// stall, branch/jump redirects and mid-request reset.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        ex_beq, ex_bne, ex_jump, ex_zero;
   logic [15:0] ex_pc;
   logic [11:0] ex_imm;
   logic        redirect;
   logic [15:0] fetch_count;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit_if #(.PC_W(16)) bus ();

   instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .ex_beq_i      (ex_beq),
      .ex_bne_i      (ex_bne),
      .ex_jump_i     (ex_jump),
      .ex_zero_i     (ex_zero),
      .ex_pc_i       (ex_pc),
      .ex_imm_i      (ex_imm),
      .redirect_o    (redirect),
      .fetch_count_o (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_beq  = 1'b0;
      ex_bne  = 1'b0;
      ex_jump = 1'b0;
      ex_zero = 1'b0;
      ex_pc   = '0;
      ex_imm  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},      32'(bus.imem_req_o),    32'h0);
      check({tag, "_addr"},     32'(bus.imem_addr_o),   32'h0);
      check({tag, "_valid"},    32'(bus.instr_valid_o), 32'h0);
      check({tag, "_instr"},    32'(bus.instr_o),       32'h0);
      check({tag, "_opcode"},   32'(bus.opcode_o),      32'h0);
      check({tag, "_pc"},       32'(bus.pc_o),          32'h0);
      check({tag, "_redirect"}, 32'(redirect),          32'h0);
      check({tag, "_count"},    32'(fetch_count),       32'h0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.imem_ack_i   = 1'b0;
      bus.imem_rdata_i = '0;
      bus.id_ready_i   = 1'b0;
      clear_ex();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // First launch, zero-wait return of 0x3123
      cycle();
      check("t1_req", 32'(bus.imem_req_o), 32'h1);
      check("t1_addr", 32'(bus.imem_addr_o), 32'h0000);
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'h3123;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("t1_valid", 32'(bus.instr_valid_o), 32'h1);
      check("t1_instr", 32'(bus.instr_o), 32'h3123);
      check("t1_opcode", 32'(bus.opcode_o), 32'h3);
      check("t1_pc", 32'(bus.pc_o), 32'h0000);
      check("t1_req_low", 32'(bus.imem_req_o), 32'h0);

      // Decode stalls four cycles
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("stall_valid", 32'(bus.instr_valid_o), 32'h1);
         check("stall_instr", 32'(bus.instr_o), 32'h3123);
         check("stall_pc", 32'(bus.pc_o), 32'h0000);
         check("stall_req", 32'(bus.imem_req_o), 32'h0);
         check("stall_count", 32'(fetch_count), 32'h0);
      end
      bus.id_ready_i = 1'b1;
      cycle();
      bus.id_ready_i = 1'b0;
      check("accept_count", 32'(fetch_count), 32'h1);
      check("accept_valid", 32'(bus.instr_valid_o), 32'h0);
      check("accept_req", 32'(bus.imem_req_o), 32'h1);
      check("accept_addr", 32'(bus.imem_addr_o), 32'h0001);

      // Zero-wait stream over addresses 1..4
      for (int a = 1; a <= 4; a++) begin
         check("zw_addr", 32'(bus.imem_addr_o), 32'(a));
         bus.imem_ack_i   = 1'b1;
         bus.imem_rdata_i = 16'h1000 | 16'(a);
         cycle();
         bus.imem_ack_i = 1'b0;
         check("zw_valid", 32'(bus.instr_valid_o), 32'h1);
         check("zw_instr", 32'(bus.instr_o), 32'h1000 | 32'(a));
         check("zw_pc", 32'(bus.pc_o), 32'(a));
         bus.id_ready_i = 1'b1;
         cycle();
         bus.id_ready_i = 1'b0;
      end
      check("zw_count", 32'(fetch_count), 32'h5);

      // Ack delayed three cycles at 0x0005
      for (int i = 0; i < 3; i++) begin
         check("wait_req", 32'(bus.imem_req_o), 32'h1);
         check("wait_addr", 32'(bus.imem_addr_o), 32'h0005);
         check("wait_valid", 32'(bus.instr_valid_o), 32'h0);
         cycle();
      end
      check("wait_addr_last", 32'(bus.imem_addr_o), 32'h0005);
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'h5AB5;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("wait_instr", 32'(bus.instr_o), 32'h5AB5);
      check("wait_pc", 32'(bus.pc_o), 32'h0005);
      cycle();
      check("wait_one_valid", 32'(bus.instr_valid_o), 32'h1);
      check("wait_no_req", 32'(bus.imem_req_o), 32'h0);
      bus.id_ready_i = 1'b1;
      cycle();
      bus.id_ready_i = 1'b0;
      check("wait_count", 32'(fetch_count), 32'h6);
      check("wait_next_addr", 32'(bus.imem_addr_o), 32'h0006);

      // Taken BEQ while an instruction waits for decode
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'h6666;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("beq_pre_valid", 32'(bus.instr_valid_o), 32'h1);
      ex_beq         = 1'b1;
      ex_zero        = 1'b1;
      ex_pc          = 16'h0010;
      ex_imm         = 12'h00E;
      bus.id_ready_i = 1'b1;
      cycle();
      clear_ex();
      bus.id_ready_i = 1'b0;
      check("beq_redirect", 32'(redirect), 32'h1);
      check("beq_addr", 32'(bus.imem_addr_o), 32'h000F);
      check("beq_req", 32'(bus.imem_req_o), 32'h1);
      check("beq_valid", 32'(bus.instr_valid_o), 32'h0);
      check("beq_count", 32'(fetch_count), 32'h6);
      cycle();
      check("beq_pulse_end", 32'(redirect), 32'h0);

      // BNE with zero set: not taken
      ex_bne  = 1'b1;
      ex_zero = 1'b1;
      ex_pc   = 16'h0010;
      ex_imm  = 12'h00E;
      cycle();
      clear_ex();
      check("bne_redirect", 32'(redirect), 32'h0);
      check("bne_addr", 32'(bus.imem_addr_o), 32'h000F);
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'hF00F;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("bne_pc", 32'(bus.pc_o), 32'h000F);
      bus.id_ready_i = 1'b1;
      cycle();
      bus.id_ready_i = 1'b0;
      check("pre_jump_addr", 32'(bus.imem_addr_o), 32'h0010);

      // Jump with a request outstanding: addr held, returned data dropped
      ex_jump = 1'b1;
      ex_pc   = 16'h1005;
      ex_imm  = 12'h234;
      cycle();
      clear_ex();
      check("jmp_redirect", 32'(redirect), 32'h1);
      check("jmp_hold_addr", 32'(bus.imem_addr_o), 32'h0010);
      check("jmp_hold_req", 32'(bus.imem_req_o), 32'h1);
      cycle();
      check("jmp_hold_addr2", 32'(bus.imem_addr_o), 32'h0010);
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'hBAD0;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("jmp_drop_valid", 32'(bus.instr_valid_o), 32'h0);
      check("jmp_addr", 32'(bus.imem_addr_o), 32'h1234);
      check("jmp_req", 32'(bus.imem_req_o), 32'h1);
      cycle();
      check("jmp_drop_valid2", 32'(bus.instr_valid_o), 32'h0);

      // Jump in the same cycle as an ack: data dropped, relaunch immediately
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'hDEAD;
      ex_jump          = 1'b1;
      ex_pc            = 16'h2000;
      ex_imm           = 12'h055;
      cycle();
      bus.imem_ack_i = 1'b0;
      clear_ex();
      check("jack_valid", 32'(bus.instr_valid_o), 32'h0);
      check("jack_addr", 32'(bus.imem_addr_o), 32'h2055);
      check("jack_redirect", 32'(redirect), 32'h1);
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 16'h7055;
      cycle();
      bus.imem_ack_i = 1'b0;
      check("jack_pc", 32'(bus.pc_o), 32'h2055);
      check("jack_opcode", 32'(bus.opcode_o), 32'h7);

      // Taken BNE with negative offset wrapping below zero
      ex_bne  = 1'b1;
      ex_zero = 1'b0;
      ex_pc   = 16'h0000;
      ex_imm  = 12'hFF8;
      cycle();
      clear_ex();
      check("wrap_addr", 32'(bus.imem_addr_o), 32'hFFF9);
      check("wrap_valid", 32'(bus.instr_valid_o), 32'h0);
      check("wrap_count", 32'(fetch_count), 32'h7);

      // Asynchronous reset in the middle of a request
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      check("post_rst_req", 32'(bus.imem_req_o), 32'h1);
      check("post_rst_addr", 32'(bus.imem_addr_o), 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
